// File: rtl/pixel_stream_gen.sv
// pixel_stream_gen
//   Producer of the pixel_x / pixel_y / pixel_valid / VGA_VS_out stream read by
//   the corner tracker. It follows the VGA scan-out, keeps the screen
//   coordinate of every active pixel, and classifies each pixel against an
//   inclusive RGB window. A pixel is emitted (pixel_valid=1) once it is at
//   least the MIN_RUN-th consecutive match on its line.
//
//   Pipeline: inputs -> stage 1 (registered RGB/coords/flags) -> stage 2
//   (classification, run tracking, registered outputs). A pixel presented on
//   the inputs shows up on pixel_* exactly two clocks later, and VGA_VS_out
//   carries the same two-clock delay.
//
// Ports
//   clk            pixel clock
//   reset          asynchronous, active-low reset
//   VGA_VS         vertical sync, active-low
//   VGA_BLANK_N    high during active video
//   VGA_R/G/B      current pixel colour, 8 bits per channel
//   r/g/b_min/max  inclusive colour window per channel (sampled live)
//   enable         low forces pixel_valid low; counters keep running
//   pixel_x/y      coordinate of the emitted pixel (11-bit signed, never < 0)
//   pixel_valid    emitted pixel is a qualified match
//   VGA_VS_out     VGA_VS delayed by two clocks
//   match_count    qualified pixels of the previous frame, latched at frame start
module pixel_stream_gen #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int MIN_RUN  = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               VGA_VS,
  input  logic               VGA_BLANK_N,
  input  logic [7:0]         VGA_R,
  input  logic [7:0]         VGA_G,
  input  logic [7:0]         VGA_B,
  input  logic [7:0]         r_min,
  input  logic [7:0]         r_max,
  input  logic [7:0]         g_min,
  input  logic [7:0]         g_max,
  input  logic [7:0]         b_min,
  input  logic [7:0]         b_max,
  input  logic               enable,
  output logic signed [10:0] pixel_x,
  output logic signed [10:0] pixel_y,
  output logic               pixel_valid,
  output logic               VGA_VS_out,
  output logic [18:0]        match_count
);

  localparam int XW = $clog2(H_ACTIVE);
  localparam int YW = $clog2(V_ACTIVE);
  localparam logic [XW-1:0] X_LAST  = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(V_ACTIVE - 1);
  localparam logic [XW-1:0] X_ONE   = XW'(1);
  localparam logic [YW-1:0] Y_ONE   = YW'(1);
  localparam logic [3:0]    RUN_MAX = 4'd15;
  localparam logic [3:0]    RUN_MIN = 4'(MIN_RUN);
  localparam logic [18:0]   ACC_MAX = 19'h7FFFF;

  // Inclusive window test; an inverted window (lo > hi) can never match.
  function automatic logic in_window(input logic [7:0] v,
                                     input logic [7:0] lo,
                                     input logic [7:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic          vs_q, vs_d;
  logic          blank_q, blank_d;
  logic [XW-1:0] x_cnt_q, x_cnt_d;
  logic [YW-1:0] y_cnt_q, y_cnt_d;
  logic          x_sat_q, x_sat_d;      // a pixel past the last column was seen
  logic          y_sat_q, y_sat_d;      // a line past the last row is in progress
  logic          line_seen_q, line_seen_d;
  logic          frame_synced_q, frame_synced_d;

  logic [7:0]    s1_r_q, s1_r_d;
  logic [7:0]    s1_g_q, s1_g_d;
  logic [7:0]    s1_b_q, s1_b_d;
  logic [XW-1:0] s1_x_q, s1_x_d;
  logic [YW-1:0] s1_y_q, s1_y_d;
  logic          s1_active_q, s1_active_d;
  logic          s1_ovf_q, s1_ovf_d;
  logic          s1_fs_q, s1_fs_d;

  logic [3:0]         run_q, run_d;
  logic signed [10:0] pixel_x_q, pixel_x_d;
  logic signed [10:0] pixel_y_q, pixel_y_d;
  logic               pixel_valid_q, pixel_valid_d;
  logic               vs_out_q, vs_out_d;
  logic [18:0]        frame_acc_q, frame_acc_d;
  logic [18:0]        match_count_q, match_count_d;

  logic       frame_start_s;
  logic       line_end_s;
  logic       match_s;
  logic [3:0] run_inc_s;
  logic [3:0] run_next_s;

  // Edge detection against the registered copies of VS and BLANK_N.
  always_comb begin
    vs_d          = VGA_VS;
    blank_d       = VGA_BLANK_N;
    frame_start_s = vs_q & ~VGA_VS;
    line_end_s    = blank_q & ~VGA_BLANK_N;
  end

  // Scan position tracking: x per active pixel, y per non-empty line.
  always_comb begin
    x_cnt_d        = x_cnt_q;
    y_cnt_d        = y_cnt_q;
    x_sat_d        = x_sat_q;
    y_sat_d        = y_sat_q;
    line_seen_d    = line_seen_q;
    frame_synced_d = frame_synced_q | frame_start_s;
    if (frame_start_s) begin
      // Frame start wins over everything, even mid-line; the pixel on the
      // inputs this cycle still uses the old coordinate, x restarts next cycle.
      x_cnt_d     = {XW{1'b0}};
      y_cnt_d     = {YW{1'b0}};
      x_sat_d     = 1'b0;
      y_sat_d     = 1'b0;
      line_seen_d = 1'b0;
    end else if (line_end_s) begin
      x_cnt_d = {XW{1'b0}};
      x_sat_d = 1'b0;
      if (line_seen_q) begin
        line_seen_d = 1'b0;
        if (y_cnt_q == Y_LAST) begin
          y_sat_d = 1'b1;
        end else begin
          y_cnt_d = y_cnt_q + Y_ONE;
        end
      end else begin
        line_seen_d = 1'b0;
      end
    end else if (VGA_BLANK_N) begin
      line_seen_d = 1'b1;
      if (x_cnt_q == X_LAST) begin
        x_sat_d = 1'b1;
      end else begin
        x_cnt_d = x_cnt_q + X_ONE;
      end
    end else begin
      line_seen_d = line_seen_q;
    end
  end

  // Stage 1: capture the pixel with its coordinate and qualifying flags.
  always_comb begin
    s1_r_d      = VGA_R;
    s1_g_d      = VGA_G;
    s1_b_d      = VGA_B;
    s1_x_d      = x_cnt_q;
    s1_y_d      = y_cnt_q;
    s1_active_d = VGA_BLANK_N;
    // Overflow marks pixels beyond the last column or on lines past the last
    // row; the saturated counter value itself would otherwise look legal.
    s1_ovf_d    = x_sat_q | y_sat_q;
    s1_fs_d     = frame_start_s;
  end

  // Stage 2: classify, track the run, and build the registered outputs.
  always_comb begin
    match_s = s1_active_q & ~s1_ovf_q
            & in_window(s1_r_q, r_min, r_max)
            & in_window(s1_g_q, g_min, g_max)
            & in_window(s1_b_q, b_min, b_max);
    run_inc_s  = (run_q == RUN_MAX) ? RUN_MAX : (run_q + 4'd1);
    run_next_s = match_s ? run_inc_s : 4'd0;
    // Blanked pixels never match, so a line end always breaks the run; a
    // frame start mid-line clears it after the pixel that arrived with it.
    run_d = s1_fs_q ? 4'd0 : run_next_s;

    pixel_valid_d = enable & frame_synced_q & match_s & (run_next_s >= RUN_MIN);

    if (pixel_valid_d) begin
      pixel_x_d = {{(11 - XW){1'b0}}, s1_x_q};
      pixel_y_d = {{(11 - YW){1'b0}}, s1_y_q};
    end else begin
      pixel_x_d = pixel_x_q;
      pixel_y_d = pixel_y_q;
    end

    // vs_q is already the one-clock copy, so this lands two clocks late.
    vs_out_d = vs_q;

    if (frame_start_s) begin
      match_count_d = frame_acc_q;
      frame_acc_d   = pixel_valid_d ? 19'd1 : 19'd0;
    end else if (pixel_valid_d && (frame_acc_q != ACC_MAX)) begin
      match_count_d = match_count_q;
      frame_acc_d   = frame_acc_q + 19'd1;
    end else begin
      match_count_d = match_count_q;
      frame_acc_d   = frame_acc_q;
    end
  end

  // All state flops; VS copies reset to the idle (high) level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vs_q           <= 1'b1;
      blank_q        <= 1'b0;
      x_cnt_q        <= {XW{1'b0}};
      y_cnt_q        <= {YW{1'b0}};
      x_sat_q        <= 1'b0;
      y_sat_q        <= 1'b0;
      line_seen_q    <= 1'b0;
      frame_synced_q <= 1'b0;
      s1_r_q         <= 8'd0;
      s1_g_q         <= 8'd0;
      s1_b_q         <= 8'd0;
      s1_x_q         <= {XW{1'b0}};
      s1_y_q         <= {YW{1'b0}};
      s1_active_q    <= 1'b0;
      s1_ovf_q       <= 1'b0;
      s1_fs_q        <= 1'b0;
      run_q          <= 4'd0;
      pixel_x_q      <= 11'sd0;
      pixel_y_q      <= 11'sd0;
      pixel_valid_q  <= 1'b0;
      vs_out_q       <= 1'b1;
      frame_acc_q    <= 19'd0;
      match_count_q  <= 19'd0;
    end else begin
      vs_q           <= vs_d;
      blank_q        <= blank_d;
      x_cnt_q        <= x_cnt_d;
      y_cnt_q        <= y_cnt_d;
      x_sat_q        <= x_sat_d;
      y_sat_q        <= y_sat_d;
      line_seen_q    <= line_seen_d;
      frame_synced_q <= frame_synced_d;
      s1_r_q         <= s1_r_d;
      s1_g_q         <= s1_g_d;
      s1_b_q         <= s1_b_d;
      s1_x_q         <= s1_x_d;
      s1_y_q         <= s1_y_d;
      s1_active_q    <= s1_active_d;
      s1_ovf_q       <= s1_ovf_d;
      s1_fs_q        <= s1_fs_d;
      run_q          <= run_d;
      pixel_x_q      <= pixel_x_d;
      pixel_y_q      <= pixel_y_d;
      pixel_valid_q  <= pixel_valid_d;
      vs_out_q       <= vs_out_d;
      frame_acc_q    <= frame_acc_d;
      match_count_q  <= match_count_d;
    end
  end

  assign pixel_x     = pixel_x_q;
  assign pixel_y     = pixel_y_q;
  assign pixel_valid = pixel_valid_q;
  assign VGA_VS_out  = vs_out_q;
  assign match_count = match_count_q;

endmodule

// File: tb/tb_pixel_stream_gen.sv
// Self-checking bench for pixel_stream_gen: stimulus pushes expected
// emissions (coordinate and arrival cycle) into a queue; a monitor on the
// falling clock edge pops and compares whenever pixel_valid is high.
module tb_pixel_stream_gen;

  localparam int HA = 640;
  localparam int VA = 480;
  localparam int MR = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic VGA_VS = 1'b1;
  logic VGA_BLANK_N = 1'b0;
  logic [7:0] VGA_R = 8'd0, VGA_G = 8'd0, VGA_B = 8'd0;
  logic [7:0] r_min = 8'd200, r_max = 8'd255;
  logic [7:0] g_min = 8'd0, g_max = 8'd50;
  logic [7:0] b_min = 8'd0, b_max = 8'd50;
  logic enable = 1'b1;
  logic signed [10:0] pixel_x, pixel_y;
  logic pixel_valid, VGA_VS_out;
  logic [18:0] match_count;

  pixel_stream_gen #(.H_ACTIVE(HA), .V_ACTIVE(VA), .MIN_RUN(MR)) dut (
    .clk(clk), .reset(reset), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .r_min(r_min), .r_max(r_max), .g_min(g_min), .g_max(g_max),
    .b_min(b_min), .b_max(b_max), .enable(enable),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_valid(pixel_valid),
    .VGA_VS_out(VGA_VS_out), .match_count(match_count)
  );

  always #5 clk = ~clk;

  typedef struct { int x; int y; int cyc; } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state: line index within the frame, sync flag, count of
  // emitted pixels in the current frame.
  int m_y = 0;
  bit m_synced = 1'b0;
  int m_acc = 0;
  logic [23:0] line_buf [0:1023];

  localparam logic [23:0] RED   = 24'hFF0000;
  localparam logic [23:0] BLACK = 24'h000000;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
    end
  endtask

  function automatic bit in_win(input logic [23:0] c);
    return (c[23:16] >= r_min) && (c[23:16] <= r_max) &&
           (c[15:8]  >= g_min) && (c[15:8]  <= g_max) &&
           (c[7:0]   >= b_min) && (c[7:0]   <= b_max);
  endfunction

  task automatic drive_pix(input bit act, input logic [23:0] c);
    @(posedge clk);
    #1;
    VGA_BLANK_N = act;
    {VGA_R, VGA_G, VGA_B} = c;
  endtask

  task automatic fill(input int len, input logic [23:0] c);
    for (int i = 0; i < len; i++) line_buf[i] = c;
  endtask

  task automatic reset_checks();
    chk("rst_valid", int'(pixel_valid), 0);
    chk("rst_x", int'(pixel_x), 0);
    chk("rst_y", int'(pixel_y), 0);
    chk("rst_match_count", int'(match_count), 0);
    chk("rst_vs_out", int'(VGA_VS_out), 1);
  endtask

  // Drive one active line of `len` pixels from line_buf, then a 2-pixel gap.
  // rst_at >= 0 pulses reset right after that pixel is put on the bus.
  task automatic send_line(input int len, input int rst_at);
    int run = 0;
    bit m;
    for (int i = 0; i < len; i++) begin
      drive_pix(1'b1, line_buf[i]);
      if (i == rst_at) begin
        reset = 1'b0;
        #1;
        reset_checks();
        m_synced = 1'b0;
        m_acc = 0;
        @(posedge clk);
        #1;
        reset = 1'b1;
      end else begin
        m = (i < HA) && (m_y < VA) && in_win(line_buf[i]);
        run = m ? run + 1 : 0;
        if (m && run >= MR && enable && m_synced) begin
          exp_q.push_back('{x: i, y: m_y, cyc: cyc + 2});
          m_acc++;
        end
      end
    end
    drive_pix(1'b0, BLACK);
    drive_pix(1'b0, BLACK);
    m_y++;
  endtask

  // Vertical sync during blanking; checks the latched previous-frame count.
  task automatic do_vsync();
    int exp_mc;
    repeat (3) drive_pix(1'b0, BLACK);
    @(posedge clk);
    #1;
    VGA_VS = 1'b0;
    exp_mc = m_acc;
    m_acc = 0;
    m_synced = 1'b1;
    m_y = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("match_count", int'(match_count), exp_mc);
    @(posedge clk);
    #1;
    VGA_VS = 1'b1;
    repeat (3) drive_pix(1'b0, BLACK);
  endtask

  function automatic logic [7:0] pick(input logic [7:0] lo, input logic [7:0] hi);
    return 8'($urandom_range(int'(hi), int'(lo)));
  endfunction

  // Monitor: VS lag, scoreboard pops on valid, hold check otherwise.
  int last_x = 0, last_y = 0;
  logic vs_h1 = 1'b1, vs_h2 = 1'b1;
  exp_t e;
  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      last_x = 0;
      last_y = 0;
      vs_h1 = 1'b1;
      vs_h2 = 1'b1;
    end else begin
      chk("vs_out_lag", int'(VGA_VS_out), int'(vs_h2));
      vs_h2 = vs_h1;
      vs_h1 = VGA_VS;
      if (pixel_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid actual=1 expected=0 x=%0d y=%0d cyc=%0d",
                   pixel_x, pixel_y, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("pixel_x", int'(pixel_x), e.x);
          chk("pixel_y", int'(pixel_y), e.y);
          chk("latency_cycle", cyc, e.cyc);
          last_x = e.x;
          last_y = e.y;
        end
      end else begin
        chk("hold_x", int'(pixel_x), last_x);
        chk("hold_y", int'(pixel_y), last_y);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] t;
    repeat (3) @(posedge clk);
    #1;
    reset_checks();
    reset = 1'b1;

    // Black frame: nothing may qualify.
    do_vsync();
    for (int y = 0; y < 6; y++) begin
      fill(HA, BLACK);
      send_line(HA, -1);
    end
    do_vsync();

    // Red 10x4 box at x 100..109, y 50..53.
    for (int y = 0; y < 56; y++) begin
      fill(120, BLACK);
      if (y >= 50 && y <= 53) for (int x = 100; x < 110; x++) line_buf[x] = RED;
      send_line(120, -1);
    end
    do_vsync();

    // Same box, output disabled.
    enable = 1'b0;
    for (int y = 0; y < 56; y++) begin
      fill(120, BLACK);
      if (y >= 50 && y <= 53) for (int x = 100; x < 110; x++) line_buf[x] = RED;
      send_line(120, -1);
    end
    do_vsync();
    enable = 1'b1;

    // Run boundaries within a line and across lines.
    fill(20, BLACK);
    line_buf[10] = RED; line_buf[11] = RED;
    for (int x = 13; x <= 16; x++) line_buf[x] = RED;
    send_line(20, -1);
    fill(HA, BLACK);
    line_buf[638] = RED; line_buf[639] = RED;
    send_line(HA, -1);
    fill(5, BLACK);
    line_buf[0] = RED; line_buf[1] = RED;
    send_line(5, -1);
    do_vsync();

    // Reset in the middle of line 200; gated until the next frame start.
    for (int y = 0; y <= 200; y++) begin
      fill(8, RED);
      send_line(8, (y == 200) ? 4 : -1);
    end
    for (int y = 0; y < 3; y++) begin
      fill(8, RED);
      send_line(8, -1);
    end
    do_vsync();
    for (int y = 0; y < 2; y++) begin
      fill(8, RED);
      send_line(8, -1);
    end
    do_vsync();

    // Inverted red window blocks every colour.
    r_min = 8'd10; r_max = 8'd5;
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 64; x++) line_buf[x] = 24'($urandom);
      line_buf[0] = RED; line_buf[1] = 24'h070000; line_buf[2] = 24'h070000;
      line_buf[3] = 24'h070000;
      send_line(64, -1);
    end
    do_vsync();
    r_min = 8'd200; r_max = 8'd255;

    // Over-long line: x saturates, nothing beyond column 639 is emitted.
    fill(700, RED);
    send_line(700, -1);
    do_vsync();

    // Over-tall frame: lines beyond row 479 are never emitted.
    for (int y = 0; y < VA + 2; y++) begin
      fill(4, RED);
      send_line(4, -1);
    end
    do_vsync();

    // Randomized windows, enable, line lengths and colours.
    for (int f = 0; f < 3; f++) begin
      t = 8'($urandom_range(0, 200));
      r_min = t; r_max = 8'(t + $urandom_range(0, 55));
      t = 8'($urandom_range(0, 200));
      g_min = t; g_max = 8'(t + $urandom_range(0, 55));
      t = 8'($urandom_range(0, 200));
      b_min = t; b_max = 8'(t + $urandom_range(0, 55));
      if ($urandom_range(0, 3) == 0) begin
        b_min = 8'(b_max + 8'd1);
        if (b_max == 8'd255) b_max = 8'd254;
      end
      enable = ($urandom_range(0, 4) != 0);
      for (int y = 0; y < 12; y++) begin
        int len;
        len = $urandom_range(20, 150);
        for (int x = 0; x < len; x++) begin
          if ($urandom_range(0, 9) < 7)
            line_buf[x] = {pick(r_min, r_max), pick(g_min, g_max), pick(b_min, b_max)};
          else
            line_buf[x] = 24'($urandom);
        end
        send_line(len, -1);
      end
      do_vsync();
    end

    repeat (10) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_stream_gen.md
Name: pixel_stream_gen

Overview:
- Producer end of the pixel_x / pixel_y / pixel_valid / VGA_VS stream that the corner-tracking FSM consumes.
- Watches the VGA scan-out (sync, blank, RGB) and tracks the screen coordinate of each active pixel.
- Classifies each active pixel against a programmable RGB colour window.
- Emits the coordinate, with pixel_valid high, for every pixel that sits inside a qualifying run of matching pixels.
- Sits between the VGA controller and the tracker. Outputs are registered and aligned with a delayed copy of VGA_VS.

Parameters:
- H_ACTIVE, 640, active pixels per line; x range 0..H_ACTIVE-1.
- V_ACTIVE, 480, active lines per frame; y range 0..V_ACTIVE-1.
- MIN_RUN, 3, number of consecutive matching pixels on a line needed before pixel_valid asserts (1..15).

Ports:
- clk  in  1  pixel clock.
- reset  in  1  asynchronous, active-low reset.
- VGA_VS  in  1  vertical sync, active-low.
- VGA_BLANK_N  in  1  high during active video.
- VGA_R  in  8  red channel of the current pixel.
- VGA_G  in  8  green channel of the current pixel.
- VGA_B  in  8  blue channel of the current pixel.
- r_min, r_max  in  8 each  inclusive red window.
- g_min, g_max  in  8 each  inclusive green window.
- b_min, b_max  in  8 each  inclusive blue window.
- enable  in  1  when low, pixel_valid is forced low; counters keep running.
- pixel_x  out  11 signed  x of the emitted pixel.
- pixel_y  out  11 signed  y of the emitted pixel.
- pixel_valid  out  1  emitted pixel is a qualified match.
- VGA_VS_out  out  1  VGA_VS delayed 2 cycles, aligned with pixel_* for the consumer.
- match_count  out  19  qualified pixels in the previous frame, latched at frame start.

Behaviour:
- Reset (reset=0, async): all outputs 0 except VGA_VS_out=1. x_cnt=0, y_cnt=0, run_cnt=0, line_seen=0, frame_acc=0.
- Edge detection uses registered copies of VGA_VS and VGA_BLANK_N.
- Frame start = falling edge of VGA_VS. At frame start:
  - y_cnt<=0, x_cnt<=0, run_cnt<=0.
  - match_count<=frame_acc.
  - frame_acc<=0, or <=1 if a qualified pixel is emitted in that same cycle.
- Active pixel = VGA_BLANK_N=1. On each active pixel:
  - x_cnt increments, saturating at H_ACTIVE-1.
  - line_seen<=1.
- Line end = falling edge of VGA_BLANK_N:
  - x_cnt<=0, run_cnt<=0.
  - If line_seen=1: y_cnt increments (saturating at V_ACTIVE-1), then line_seen<=0.
  - Blank lines never advance y.
- Pipeline stage 1 (cycle N+1): register RGB, x_cnt, y_cnt, active flag, and overflow flag (x or y counter already saturated).
- Pipeline stage 2 (cycle N+2):
  - match = active & ~overflow & every channel inside its window (bounds inclusive).
  - run_cnt = match ? min(run_cnt+1, 15) : 0. Run is cleared at line end.
  - pixel_valid = enable & match & (run_cnt_next >= MIN_RUN).
  - pixel_x / pixel_y take the stage-1 coordinate, zero-extended into 11 bits, never negative.
- Latency: exactly 2 clk from a pixel on the inputs to its pixel_valid. VGA_VS_out carries the same 2-cycle delay.
- Only pixels from the MIN_RUN-th match of a run onward are emitted; the leading MIN_RUN-1 pixels of a run are dropped.
- frame_acc increments on each qualified pixel and saturates at 2^19-1.
- Inverted window (min>max) on any channel: that channel never matches, so pixel_valid stays 0.
- Threshold inputs are sampled live; a change mid-line affects pixels from the next stage-2 cycle onward.
- Frame start in the middle of a line (VS falls while BLANK_N=1): counters clear as above; x_cnt restarts at 0 on the next cycle.
- Reset asserted mid-frame: outputs clear immediately. After release, no pixel_valid until the first frame start.
  - Gated by a frame_synced flag, which is set at frame start and cleared by reset.
- pixel_x and pixel_y hold their last value while pixel_valid=0.

Test Plan:
- Reset then one 640x480 frame of black with window R 200..255, G 0..50, B 0..50: pixel_valid never 1; at the next VS fall match_count=0; VGA_VS_out lags VGA_VS by exactly 2 clk.
- Red 10x4 box at x 100..109, y 50..53, MIN_RUN=3: pixel_valid high for x=102..109 on each of y=50..53, first assertion 2 clk after the pixel at x=102; next frame match_count=32.
- Same box with enable=0: pixel_valid stays 0; match_count=0.
- Line with matches at x=10,11, gap at 12, then x=13..16 (MIN_RUN=3): valid only for x=15,16; runs do not carry across lines (match at x=638,639 then x=0 of the next line gives no valid at x=0).
- Assert reset mid-line at y=200 and release: outputs are 0 immediately; no pixel_valid until after the next VS fall; the next frame restarts at y=0.
- Set r_min=10, r_max=5: pixel_valid is 0 for all colours. Then use a 700-pixel active line: x saturates at 639, and pixels beyond 639 are never emitted.
